// File: rtl/conf_int_mac_seq_apx.sv
// Configurable-precision unsigned multiply-accumulate engine.
// Streams len masked operand pairs through a 2-stage multiply pipeline onto a latched bias.
module conf_int_mac_seq_apx #(
  parameter int OP_BITWIDTH        = 16,
  parameter int DATA_PATH_BITWIDTH = 16,
  parameter int ACC_BITWIDTH       = 40,
  parameter int LEN_BITWIDTH       = 8,
  parameter int SATURATE           = 1,
  localparam int PREC_W            = $clog2(DATA_PATH_BITWIDTH + 1)
) (
  input  logic                          clk,
  input  logic                          racc,
  input  logic                          start,
  input  logic [LEN_BITWIDTH-1:0]       len,
  input  logic [PREC_W-1:0]             prec,
  input  logic [ACC_BITWIDTH-1:0]       acc_init,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_PATH_BITWIDTH-1:0] a,
  input  logic [DATA_PATH_BITWIDTH-1:0] b,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ACC_BITWIDTH-1:0]       d,
  output logic                          ovf,
  output logic                          busy
);

  localparam int DW = DATA_PATH_BITWIDTH;
  localparam int PW = 2 * DATA_PATH_BITWIDTH;
  localparam int AW = ACC_BITWIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                  state;
  logic [LEN_BITWIDTH-1:0] remaining;
  logic [PREC_W-1:0]       k_reg;
  logic [PREC_W-1:0]       k_in;
  logic [DW-1:0]           op_mask;
  logic [AW-1:0]           bias_mask;
  logic [DW-1:0]           a_q;
  logic [DW-1:0]           b_q;
  logic                    v1;
  logic [PW-1:0]           prod;
  logic                    v2;
  logic [AW-1:0]           acc;
  logic [AW:0]             sum;
  logic                    accept;

  // k = number of low bits discarded per operand for the incoming job
  always_comb begin
    k_in = '0;
    if (prec == '0 || int'(prec) > DW)
      k_in = PREC_W'(DW - OP_BITWIDTH);
    else
      k_in = PREC_W'(DW) - prec;
  end

  for (genvar gi = 0; gi < DW; gi++) begin : g_op_mask
    assign op_mask[gi] = (gi >= int'(k_reg));
  end

  for (genvar gi = 0; gi < AW; gi++) begin : g_bias_mask
    assign bias_mask[gi] = (gi >= 2 * int'(k_in));
  end

  assign in_ready = (state == RUN) && (remaining != '0);
  assign accept   = in_valid && in_ready;
  assign busy     = (state != IDLE);
  assign sum      = {1'b0, acc} + (AW+1)'(prod);

  always_ff @(posedge clk or negedge racc) begin
    if (!racc) begin
      state     <= IDLE;
      remaining <= '0;
      k_reg     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      v1        <= 1'b0;
      prod      <= '0;
      v2        <= 1'b0;
      acc       <= '0;
      d         <= '0;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      v1 <= accept;
      if (accept) begin
        a_q <= a & op_mask;
        b_q <= b & op_mask;
      end

      v2 <= v1;
      if (v1)
        prod <= PW'(a_q) * PW'(b_q);

      // once saturated, further adds keep carrying out, so the clamp holds
      if (v2) begin
        if (sum[AW]) begin
          ovf <= 1'b1;
          acc <= (SATURATE != 0) ? '1 : sum[AW-1:0];
        end else begin
          acc <= sum[AW-1:0];
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            remaining <= len;
            k_reg     <= k_in;
            acc       <= acc_init & bias_mask;
            ovf       <= 1'b0;
            if (len == '0) begin
              d         <= acc_init & bias_mask;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (accept) begin
            remaining <= remaining - 1'b1;
            if (remaining == LEN_BITWIDTH'(1))
              state <= DRAIN;
          end
        end
        DRAIN: begin
          // pipeline empty means the last product has landed in acc
          if (!v1 && !v2) begin
            d         <= acc;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
